// File: rtl/proc_io_pkg.sv
// Shared constants and helpers for the processor I/O feeder blocks.
package proc_io_pkg;

  localparam int NUBITS_DEF = 23;
  localparam int DEPTH_DEF  = 8;

  // Occupancy needs one bit more than the address so that "full" (== DEPTH) is representable
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/proc_in_feeder_if.sv
// Bundle of the upstream stream, processor request and status signals around one feeder.
interface proc_in_feeder_if
  import proc_io_pkg::*;
#(
  parameter int NUBITS = NUBITS_DEF,
  parameter int DEPTH  = DEPTH_DEF
);

  localparam int LEVEL_W = level_w(DEPTH);

  logic signed [NUBITS-1:0]  s_data;
  logic                      s_valid;
  logic                      s_ready;
  logic                      req_in;
  logic signed [NUBITS-1:0]  in;
  logic        [LEVEL_W-1:0] level;
  logic                      underrun;
  logic                      overflow;
  logic                      clr_flags;

  modport master (
    output s_data, s_valid, req_in, clr_flags,
    input  s_ready, in, level, underrun, overflow
  );

  modport slave (
    input  s_data, s_valid, req_in, clr_flags,
    output s_ready, in, level, underrun, overflow
  );

endinterface

// File: rtl/proc_fifo_ram.sv
// Register-array storage for the feeder FIFO: synchronous write, asynchronous read.
module proc_fifo_ram
  import proc_io_pkg::*;
#(
  parameter int NUBITS = NUBITS_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic signed [NUBITS-1:0]   wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic signed [NUBITS-1:0]   rdata
);

  logic signed [NUBITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_in_feeder.sv
// First-word-fall-through sample buffer answering the processor's req_in handshake.
module proc_in_feeder
  import proc_io_pkg::*;
#(
  parameter int NUBITS    = NUBITS_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  proc_in_feeder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]              wr_ptr, rd_ptr;
  logic signed [NUBITS-1:0] head, last_val, empty_val;
  logic                     empty, full, push, pop;
  logic                     underrun_q, overflow_q;

  // Pointers carry a wrap bit: equal means empty, differing only in the wrap bit means full
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Readiness comes from registered occupancy only; a same-cycle pop never opens a slot
  assign push = bus.s_valid && !full;
  assign pop  = bus.req_in && !empty;

  proc_fifo_ram #(
    .NUBITS (NUBITS),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.s_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_val   <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + (AW+1)'(1);
        last_val <= head;
      end
      if (bus.clr_flags)                underrun_q <= 1'b0;
      else if (bus.req_in && empty)     underrun_q <= 1'b1;
      if (bus.clr_flags)                overflow_q <= 1'b0;
      else if (bus.s_valid && full)     overflow_q <= 1'b1;
    end
  end

  assign empty_val    = HOLD_LAST ? last_val : '0;
  assign bus.in       = empty ? empty_val : head;
  assign bus.s_ready  = !full;
  assign bus.level    = wr_ptr - rd_ptr;
  assign bus.underrun = underrun_q;
  assign bus.overflow = overflow_q;

endmodule
